// File: rtl/right_shift_if.sv
// Operand/result bundle for the registered right-shift unit.
// master drives the operand side, slave (the shifter) drives the result side.
interface right_shift_if;
    logic [15:0] a;
    logic [3:0]  shamt;
    logic [1:0]  mode;
    logic        in_valid;
    logic [15:0] out;
    logic        out_valid;
    logic        carry;
    logic        zero;

    modport master (
        output a, shamt, mode, in_valid,
        input  out, out_valid, carry, zero
    );

    modport slave (
        input  a, shamt, mode, in_valid,
        output out, out_valid, carry, zero
    );
endinterface

// File: rtl/right_shift.sv
// Registered 16-bit right shifter: logical, arithmetic and optional rotate,
// with last-bit-out carry and zero flags. Rotate enabled by RIGHT_SHIFT_ROTATE_EN.
module right_shift #(
    parameter int DATA_W  = 16,
    parameter int SHAMT_W = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    right_shift_if.slave bus
);

    logic [DATA_W-1:0] shift_s;
    logic              carry_s;
    logic [DATA_W-1:0] out_r;
    logic              carry_r;
    logic              zero_r;
    logic              valid_r;

    // Combinational shift result and shifted-out bit for the current operand.
    always_comb begin
        shift_s = bus.a;
        carry_s = 1'b0;
        case (bus.mode)
            2'b01: begin
                shift_s = $unsigned($signed(bus.a) >>> bus.shamt);
            end
`ifdef RIGHT_SHIFT_ROTATE_EN
            2'b10: begin
                // A 16-place left shift of a 16-bit value is zero, so shamt 0 rotates to a.
                shift_s = (bus.a >> bus.shamt) |
                          (bus.a << (5'd16 - {1'b0, bus.shamt}));
            end
`endif
            default: begin
                shift_s = bus.a >> bus.shamt;
            end
        endcase
        if (bus.shamt != {SHAMT_W{1'b0}}) begin
            carry_s = bus.a[bus.shamt - 4'd1];
        end else begin
            carry_s = 1'b0;
        end
    end

    // Result registers: capture on in_valid, hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_r   <= 16'h0000;
            carry_r <= 1'b0;
            zero_r  <= 1'b0;
            valid_r <= 1'b0;
        end else if (bus.in_valid) begin
            out_r   <= shift_s;
            carry_r <= carry_s;
            zero_r  <= (shift_s == 16'h0000);
            valid_r <= 1'b1;
        end else begin
            valid_r <= 1'b0;
        end
    end

    assign bus.out       = out_r;
    assign bus.carry     = carry_r;
    assign bus.zero      = zero_r;
    assign bus.out_valid = valid_r;

endmodule

// File: tb/tb_right_shift.sv
// Scoreboard bench for right_shift; expected results come from a bit-level
// reference model and are compared when out_valid is seen.
module tb_right_shift;

    typedef struct {
        logic [15:0] res;
        logic        carry;
        logic        zero;
    } exp_t;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    int   pushed = 0;
    int   popped = 0;
    exp_t sb[$];
    logic [15:0] last_out;
    logic        last_carry;
    logic        last_zero;

    right_shift_if bus ();

    right_shift dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Bit-by-bit reference: each result bit picks its source bit or the fill.
    function automatic exp_t model(input logic [15:0] a, input logic [3:0] sh, input logic [1:0] md);
        exp_t e;
        int   src;
        for (int i = 0; i < 16; i++) begin
            src = i + int'(sh);
            if (src < 16) begin
                e.res[i] = a[src];
            end else begin
`ifdef RIGHT_SHIFT_ROTATE_EN
                if (md == 2'b10) e.res[i] = a[src - 16];
                else if (md == 2'b01) e.res[i] = a[15];
                else e.res[i] = 1'b0;
`else
                if (md == 2'b01) e.res[i] = a[15];
                else e.res[i] = 1'b0;
`endif
            end
        end
        e.carry = (sh == 4'd0) ? 1'b0 : a[int'(sh) - 1];
        e.zero  = (e.res == 16'h0000);
        return e;
    endfunction

    task automatic drive(input logic [15:0] a, input logic [3:0] sh, input logic [1:0] md);
        @(negedge clk);
        bus.a        = a;
        bus.shamt    = sh;
        bus.mode     = md;
        bus.in_valid = 1'b1;
        sb.push_back(model(a, sh, md));
        pushed++;
    endtask

    task automatic idle();
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Monitor: compare every fresh result against the scoreboard head.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst_n && bus.out_valid) begin
            if (sb.size() == 0) begin
                check_val("spurious_valid", 16'd1, 16'd0);
            end else begin
                e = sb.pop_front();
                popped++;
                check_val("out", bus.out, e.res);
                check_val("carry", {15'd0, bus.carry}, {15'd0, e.carry});
                check_val("zero", {15'd0, bus.zero}, {15'd0, e.zero});
                last_out   = e.res;
                last_carry = e.carry;
                last_zero  = e.zero;
            end
        end
    end

    initial begin
        int wait_cnt;
        rst_n        = 1'b0;
        bus.a        = 16'h0000;
        bus.shamt    = 4'd0;
        bus.mode     = 2'b00;
        bus.in_valid = 1'b0;
        last_out     = 16'h0000;
        last_carry   = 1'b0;
        last_zero    = 1'b0;

        // Inputs applied during reset must be ignored.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a        = 16'h1234;
        bus.shamt    = 4'd3;
        @(posedge clk);
        #2;
        check_val("rst_out", bus.out, 16'h0000);
        check_val("rst_valid", {15'd0, bus.out_valid}, 16'd0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n        = 1'b1;

        // Single-bit logical sequence.
        drive(16'h0000, 4'd1, 2'b00);
        drive(16'h000E, 4'd1, 2'b00);
        drive(16'h0003, 4'd1, 2'b00);
        // Arithmetic.
        drive(16'h8004, 4'd2, 2'b01);
        drive(16'h8004, 4'd15, 2'b01);
        // Rotate (or logical without the macro).
        drive(16'h0001, 4'd1, 2'b10);
        drive(16'h8001, 4'd4, 2'b10);
        // shamt 0 in every mode.
        for (int m = 0; m < 4; m++) drive(16'hA5A5, 4'd0, m[1:0]);
        // Reserved mode.
        drive(16'hF0F0, 4'd4, 2'b11);
        idle();

        // Hold for 3 idle cycles.
        repeat (3) begin
            @(posedge clk);
            #2;
            check_val("hold_valid", {15'd0, bus.out_valid}, 16'd0);
            check_val("hold_out", bus.out, last_out);
            check_val("hold_carry", {15'd0, bus.carry}, {15'd0, last_carry});
            check_val("hold_zero", {15'd0, bus.zero}, {15'd0, last_zero});
        end

        // Back-to-back random stream.
        for (int i = 0; i < 60; i++) begin
            drive(16'($urandom_range(0, 65535)), 4'($urandom_range(0, 15)),
                  2'($urandom_range(0, 3)));
        end
        idle();
        wait_cnt = 0;
        while (sb.size() != 0 && wait_cnt < 20) begin
            @(posedge clk);
            wait_cnt++;
        end
        #3;
        check_val("drain", 16'(sb.size()), 16'd0);
        check_val("count", 16'(popped), 16'(pushed));

        // Asynchronous reset mid-stream discards the in-flight result.
        drive(16'h0000, 4'd1, 2'b00);
        drive(16'hFFFF, 4'd3, 2'b01);
        #1;
        rst_n = 1'b0;
        #1;
        check_val("arst_out", bus.out, 16'h0000);
        check_val("arst_valid", {15'd0, bus.out_valid}, 16'd0);
        check_val("arst_carry", {15'd0, bus.carry}, 16'd0);
        check_val("arst_zero", {15'd0, bus.zero}, 16'd0);
        sb.delete();
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // First result after reset.
        drive(16'h000E, 4'd1, 2'b00);
        idle();
        repeat (2) @(posedge clk);
        #3;
        check_val("post_rst_drain", 16'(sb.size()), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time limit so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
